mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the pipelined core: instruction fetch (IF) and the load/store unit (LS).
- Sits between the fetch/LSU stages and the memory macro.
- Issues at most one outstanding transaction, with LS-first priority and an IF anti-starvation counter.
- Routes each response only to its owner, and discards in-flight fetch responses on a pipeline redirect.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive LS grants allowed while IF is pending; legal range ≥1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-low reset.
- i_if_req  in  1  fetch request; held with i_if_addr until o_if_gnt.
- i_if_addr  in  ADDR_W  fetch address.
- i_if_flush  in  1  redirect (mispredict); kills any in-flight fetch response.
- o_if_gnt  out  1  fetch request accepted this cycle.
- o_if_rvalid  out  1  fetch data valid.
- o_if_rdata  out  DATA_W  fetch data.
- i_ls_req  in  1  LSU request; held with all LS fields until o_ls_gnt.
- i_ls_wren  in  1  1 = store.
- i_ls_addr  in  ADDR_W  LSU address.
- i_ls_wdata  in  DATA_W  store data.
- i_ls_bmask  in  4  store byte enables.
- o_ls_gnt  out  1  LSU request accepted.
- o_ls_rvalid  out  1  load data valid, or store acknowledge.
- o_ls_rdata  out  DATA_W  load data; 0 for a store ack.
- o_mem_req  out  1  issue strobe to memory.
- o_mem_wren  out  1  write enable.
- o_mem_addr  out  ADDR_W  address.
- o_mem_wdata  out  DATA_W  write data.
- o_mem_bmask  out  4  byte enables.
- i_mem_rvalid  in  1  memory response; exactly one per issued request, latency ≥1 cycle.
- i_mem_rdata  in  DATA_W  response data.
- o_if_wait_cnt  out  32  perf counter (optional feature).
- o_ls_wait_cnt  out  32  perf counter (optional feature).

Behaviour:
- **Reset.** i_reset sampled low at a rising edge gives:
  - state ARB_IDLE, owner OWN_IF, starve counter 0, killed flag 0;
  - all outputs 0 (gnt, rvalid, mem_req, mem_* fields, rdata, counters).
- **Reset mid-operation.** The arbiter returns to IDLE. A later stray i_mem_rvalid is ignored.
- **Issue window.** Asserted when state == IDLE, or when state == BUSY and i_mem_rvalid == 1 (back-to-back issue, no bubble).
- **Arbitration (combinational, within the issue window).**
  - Only one requester active: that requester wins.
  - Both active: LS wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
- **Grant and memory drive.**
  - Winner sees its gnt high for exactly one cycle.
  - In that same cycle o_mem_req = 1 and the o_mem_* fields are driven combinationally from the winner.
  - A fetch always drives o_mem_wren = 0 and o_mem_bmask = 0.
- **Memory-side idle values.** When there is no issue, o_mem_req = 0 and all o_mem_* fields = 0.
- **Transitions.**
  - IDLE → BUSY on issue; owner is latched.
  - BUSY → IDLE on i_mem_rvalid with no new issue.
  - BUSY → BUSY on i_mem_rvalid with a new issue; owner is updated.
- **Response routing.**
  - In BUSY on i_mem_rvalid, the rvalid and rdata outputs of the owner are driven combinationally: the same cycle, 0 added latency. The other requester's rdata is 0.
  - i_mem_rvalid in IDLE is ignored.
- **Store acknowledge.** An LS store gets o_ls_rvalid with o_ls_rdata = 0.
- **Starve counter update.**
  - Increments on an LS grant while i_if_req == 1.
  - Clears on an IF grant, or in any cycle where i_if_req == 0.
  - Saturates at STARVE_MAX.
- **Flush (i_if_flush).**
  - Sets the killed flag while owner == OWN_IF and BUSY. The flag clears when the response arrives and that response is suppressed: o_if_rvalid = 0.
  - Flush in the same cycle as the fetch i_mem_rvalid also suppresses that response.
  - Flush does not cancel a grant issued in the same cycle. Instead that new fetch is marked killed.
  - Flush has no effect on LS transactions.
- **Simultaneous IF and LS requests in IDLE, counter < STARVE_MAX:** the cycle sees o_ls_gnt = 1 and o_if_gnt = 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - o_if_wait_cnt increments each cycle with i_if_req & ~o_if_gnt.
  - o_ls_wait_cnt increments likewise for LS.
  - Both are 32-bit wrap-around counters, cleared by reset.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  - typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;
  - localparam BMASK_W = 4.
- One sub-module, arb_starve_ctr: the saturating counter plus its priority-override flag, parameterised by STARVE_MAX.

Test Plan:
- **Single IF request.** i_if_req = 1, addr 0x100, memory latency 2.
  - Cycle 0: o_if_gnt = 1 and o_mem_addr = 0x100.
  - Cycle 2: o_if_rvalid = 1 with rdata = 0xDEADBEEF.
- **Simultaneous LS store and IF.** LS store 0x2000 / 0x12345678 / bmask 0xF together with IF 0x104.
  - Cycle 0: LS granted, o_mem_wren = 1.
  - IF is granted in the response cycle, back-to-back.
  - o_ls_rvalid = 1 with rdata = 0.
- **Starvation.** i_ls_req held high and IF held high, STARVE_MAX = 4, latency 1.
  - Grants LS, LS, LS, LS, IF, then LS again.
- **Flush kills an in-flight fetch.** Fetch 0x200 granted, then i_if_flush = 1 the next cycle, latency 3.
  - o_if_rvalid stays 0; the arbiter returns to IDLE.
  - A subsequent fetch 0x300 returns normally.
- **Reset mid-transaction.** i_reset = 0 while BUSY (LS load).
  - All outputs are 0 the next cycle.
  - A late i_mem_rvalid produces no o_ls_rvalid.
- **Perf counters (ARB_PERF_CNT_EN).** IF waits 3 cycles behind LS.
  - o_if_wait_cnt = 3.
  - Without the macro, o_if_wait_cnt = 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state, transaction
// owner and the byte-enable width used on the LS and memory sides.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int BMASK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of mem_port_arbiter.
// Handshake: a requester raises *_req and holds it with all its fields
// stable until the arbiter pulses the matching *_gnt for one cycle; the
// request is accepted in that cycle. Responses (*_rvalid) are single-cycle
// pulses with no back-pressure. The memory sees o_mem_req for one cycle per
// transaction and answers with exactly one i_mem_rvalid pulse later.
// slave = arbiter side, master = core/memory side (or a testbench).
interface mem_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    // fetch side
    logic               i_if_req;
    logic [ADDR_W-1:0]  i_if_addr;
    logic               i_if_flush;
    logic               o_if_gnt;
    logic               o_if_rvalid;
    logic [DATA_W-1:0]  o_if_rdata;

    // load/store side
    logic               i_ls_req;
    logic               i_ls_wren;
    logic [ADDR_W-1:0]  i_ls_addr;
    logic [DATA_W-1:0]  i_ls_wdata;
    logic [BMASK_W-1:0] i_ls_bmask;
    logic               o_ls_gnt;
    logic               o_ls_rvalid;
    logic [DATA_W-1:0]  o_ls_rdata;

    // memory side
    logic               o_mem_req;
    logic               o_mem_wren;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [DATA_W-1:0]  o_mem_wdata;
    logic [BMASK_W-1:0] o_mem_bmask;
    logic               i_mem_rvalid;
    logic [DATA_W-1:0]  i_mem_rdata;

    // performance counters and FSM visibility
    logic [31:0]        o_if_wait_cnt;
    logic [31:0]        o_ls_wait_cnt;
    arb_state_e         o_dbg_state;
    arb_owner_e         o_dbg_owner;

    modport slave (
        input  i_if_req, i_if_addr, i_if_flush,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_rvalid, i_mem_rdata,
        output o_if_wait_cnt, o_ls_wait_cnt, o_dbg_state, o_dbg_owner
    );

    modport master (
        output i_if_req, i_if_addr, i_if_flush,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_rvalid, i_mem_rdata,
        input  o_if_wait_cnt, o_ls_wait_cnt, o_dbg_state, o_dbg_owner
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Fetch anti-starvation counter: counts LS grants taken while a fetch is
// waiting, saturates at STARVE_MAX and then hands priority to fetch.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic ls_gnt_i,
    output logic if_prio_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: fetch idle or served clears it, LS grant over a waiting fetch bumps it
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (ls_gnt_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign if_prio_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the LSU in front
// of one unified single-port memory. LS has priority unless fetch has been
// passed over STARVE_MAX times. Responses route to the latched owner with
// zero added latency; flushed fetches have their response swallowed.
// Optional macro ARB_PERF_CNT_EN adds per-requester wait-cycle counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic       killed_q, killed_d;
    logic       store_q, store_d;

    logic issue_win, resp, if_win, ls_win, if_prio;
    logic if_rvalid, ls_rvalid;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .if_req_i  (bus.i_if_req),
        .if_gnt_i  (if_win),
        .ls_gnt_i  (ls_win),
        .if_prio_o (if_prio)
    );

    // Issue window (idle, or busy with the response arriving) and winner pick
    always_comb begin
        resp      = i_reset && (state_q == ARB_BUSY) && bus.i_mem_rvalid;
        issue_win = i_reset && ((state_q == ARB_IDLE) || resp);
        if_win    = issue_win && bus.i_if_req && (!bus.i_ls_req || if_prio);
        ls_win    = issue_win && bus.i_ls_req && !if_win;
    end

    // Memory request fields follow the winner; everything is zero otherwise
    always_comb begin
        bus.o_mem_req   = 1'b0;
        bus.o_mem_wren  = 1'b0;
        bus.o_mem_addr  = ADDR_ZERO;
        bus.o_mem_wdata = DATA_ZERO;
        bus.o_mem_bmask = '0;
        if (ls_win) begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_wren  = bus.i_ls_wren;
            bus.o_mem_addr  = bus.i_ls_addr;
            bus.o_mem_wdata = bus.i_ls_wdata;
            bus.o_mem_bmask = bus.i_ls_bmask;
        end else if (if_win) begin
            bus.o_mem_req   = 1'b1;
            bus.o_mem_addr  = bus.i_if_addr;
        end
    end

    // Response steering to the owner; killed or flushed fetches are dropped
    always_comb begin
        if_rvalid       = resp && (owner_q == OWN_IF) && !killed_q && !bus.i_if_flush;
        ls_rvalid       = resp && (owner_q == OWN_LS);
        bus.o_if_rvalid = if_rvalid;
        bus.o_ls_rvalid = ls_rvalid;
        bus.o_if_rdata  = if_rvalid ? bus.i_mem_rdata : DATA_ZERO;
        bus.o_ls_rdata  = (ls_rvalid && !store_q) ? bus.i_mem_rdata : DATA_ZERO;
        bus.o_if_gnt    = if_win;
        bus.o_ls_gnt    = ls_win;
    end

    // Next state: retire on response, (re)issue on a win, track fetch kills
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        store_d  = store_q;
        killed_d = killed_q;
        if (resp) begin
            state_d  = ARB_IDLE;
            killed_d = 1'b0;
        end else if ((state_q == ARB_BUSY) && (owner_q == OWN_IF) && bus.i_if_flush) begin
            killed_d = 1'b1;
        end
        if (if_win || ls_win) begin
            state_d  = ARB_BUSY;
            owner_d  = ls_win ? OWN_LS : OWN_IF;
            store_d  = ls_win && bus.i_ls_wren;
            // a flush does not revoke a same-cycle fetch grant, it poisons it
            killed_d = if_win && bus.i_if_flush;
        end
    end

    // FSM registers, synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            store_q  <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
            killed_q <= killed_d;
        end
    end

    assign bus.o_dbg_state = state_q;
    assign bus.o_dbg_owner = owner_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_wait_q, if_wait_d, ls_wait_q, ls_wait_d;

    // Wait counters: cycles a requester is asserted without being granted
    always_comb begin
        if_wait_d = if_wait_q + {31'd0, (bus.i_if_req && !if_win)};
        ls_wait_d = ls_wait_q + {31'd0, (bus.i_ls_req && !ls_win)};
    end

    // Wait counter registers, wrap-around, cleared by reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if_wait_q <= '0;
            ls_wait_q <= '0;
        end else begin
            if_wait_q <= if_wait_d;
            ls_wait_q <= ls_wait_d;
        end
    end

    assign bus.o_if_wait_cnt = if_wait_q;
    assign bus.o_ls_wait_cnt = ls_wait_q;
`else
    assign bus.o_if_wait_cnt = 32'd0;
    assign bus.o_ls_wait_cnt = 32'd0;
`endif

endmodule
